compress_pack: RTL and testbench

COMPRESS_PACK -- requirements
Module: compress_pack

---
 rtl/compress_pack_if.sv | 27 ++
 rtl/compress_pack.sv | 173 +++++++++++++++++
 tb/tb_compress_pack.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/compress_pack_if.sv
// Handshake bundle for compress_pack: 96-bit coefficient beats in, packed 32-bit words out.
interface compress_pack_if;
  logic [95:0] mem_rd_data;
  logic        mem_rd_data_valid;
  logic        mem_rd_data_hold;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output mem_rd_data,
    output mem_rd_data_valid,
    input  mem_rd_data_hold,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  mem_rd_data,
    input  mem_rd_data_valid,
    output mem_rd_data_hold,
    output out_data,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/compress_pack.sv
// Compresses four 12-bit coefficients per beat to d bits each and packs them LSB-first into 32-bit words.
// Optional feature: define ABR_CMP_RANGE_CHECK_EN to flag accepted coefficients >= 3329 on range_err.
module compress_pack #(
  parameter int BUF_W = 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           zeroize,
  input  logic           cmp_enable,
  input  logic [2:0]     num_poly,
  input  logic [2:0]     cmp_mode,
  compress_pack_if.slave bus,
  output logic           done,
  output logic           range_err
);
  localparam int          CNT_W  = $clog2(BUF_W + 1);
  localparam logic [23:0] Q      = 24'd3329;
  localparam logic [23:0] HALF_Q = 24'd1664;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg;
  logic [3:0]       d_reg;
  logic [8:0]       total_reg;
  logic [8:0]       beat_cnt_reg;
  logic             stage_valid_reg;
  logic [10:0]      y_reg [4];
  logic [BUF_W-1:0] buf_reg;
  logic [CNT_W-1:0] count_reg;
  logic             range_err_reg;
  logic             done_reg;
  logic             out_valid_reg;

  logic [3:0]       d_sel;
  logic             bad_mode;
  logic [10:0]      y_mask;
  logic [10:0]      y_lane [4];
  logic [15:0]      beat_bits;
  logic [15:0]      need_bits;
  logic             hold;
  logic             accept;
  logic             pop;
  logic [BUF_W-1:0] packed_bits;
  logic [BUF_W-1:0] buf_shift;
  logic [BUF_W-1:0] buf_next;
  logic [CNT_W-1:0] cnt_shift;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    d_sel    = 4'd1;
    bad_mode = 1'b0;
    case (cmp_mode)
      3'd0:    d_sel = 4'd1;
      3'd1:    d_sel = 4'd4;
      3'd2:    d_sel = 4'd5;
      3'd3:    d_sel = 4'd10;
      3'd4:    d_sel = 4'd11;
      default: bad_mode = 1'b1;
    endcase
  end

  assign y_mask = 11'((12'd1 << d_reg) - 12'd1);

`ifdef ABR_CMP_RANGE_CHECK_EN
  logic [3:0] lane_oor;
`endif

  // Round-half-up compression: floor((x*2^d + q/2) / q) mod 2^d
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [11:0] x;
    logic [11:0] unused_hi;
    logic [23:0] num;
    logic [23:0] quo;
    assign x          = bus.mem_rd_data[24*gi +: 12];
    assign unused_hi  = bus.mem_rd_data[24*gi+12 +: 12];
    assign num        = ({12'd0, x} << d_reg) + HALF_Q;
    assign quo        = num / Q;
    assign y_lane[gi] = 11'(quo) & y_mask;
`ifdef ABR_CMP_RANGE_CHECK_EN
    assign lane_oor[gi] = (x >= 12'd3329);
`endif
  end

  // Room check covers the beat sitting in the compress stage plus the one being offered
  assign beat_bits = {10'd0, d_reg, 2'b00};
  assign need_bits = 16'(count_reg) + (stage_valid_reg ? (beat_bits << 1) : beat_bits);
  assign hold      = (state_reg == RUN) && (need_bits > 16'(BUF_W));
  assign accept    = (state_reg == RUN) && bus.mem_rd_data_valid && !hold &&
                     (beat_cnt_reg != total_reg);
  assign pop       = out_valid_reg && bus.out_ready;

  always_comb begin
    packed_bits = '0;
    for (int i = 0; i < 4; i++) begin
      packed_bits = packed_bits |
                    ({{(BUF_W-11){1'b0}}, y_reg[i]} << (6'(i) * {2'b00, d_reg}));
    end
  end

  assign buf_shift  = pop ? (buf_reg >> 32) : buf_reg;
  assign cnt_shift  = pop ? (count_reg - CNT_W'(32)) : count_reg;
  assign buf_next   = stage_valid_reg ? (buf_shift | (packed_bits << cnt_shift)) : buf_shift;
  assign count_next = stage_valid_reg ? (cnt_shift + CNT_W'(beat_bits)) : cnt_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      d_reg           <= 4'd1;
      total_reg       <= '0;
      beat_cnt_reg    <= '0;
      stage_valid_reg <= 1'b0;
      for (int i = 0; i < 4; i++) y_reg[i] <= '0;
      buf_reg         <= '0;
      count_reg       <= '0;
      range_err_reg   <= 1'b0;
      done_reg        <= 1'b1;
      out_valid_reg   <= 1'b0;
    end else if (zeroize) begin
      state_reg       <= IDLE;
      d_reg           <= 4'd1;
      total_reg       <= '0;
      beat_cnt_reg    <= '0;
      stage_valid_reg <= 1'b0;
      for (int i = 0; i < 4; i++) y_reg[i] <= '0;
      buf_reg         <= '0;
      count_reg       <= '0;
      range_err_reg   <= 1'b0;
      done_reg        <= 1'b1;
      out_valid_reg   <= 1'b0;
    end else begin
      stage_valid_reg <= accept;
      buf_reg         <= buf_next;
      count_reg       <= count_next;
      out_valid_reg   <= (count_next >= CNT_W'(32));
      if (accept) begin
        for (int i = 0; i < 4; i++) y_reg[i] <= y_lane[i];
        beat_cnt_reg <= beat_cnt_reg + 9'd1;
      end
`ifdef ABR_CMP_RANGE_CHECK_EN
      if (accept && (|lane_oor)) range_err_reg <= 1'b1;
`endif
      case (state_reg)
        IDLE: begin
          if (cmp_enable) begin
            state_reg     <= RUN;
            done_reg      <= 1'b0;
            d_reg         <= d_sel;
            total_reg     <= {num_poly, 6'd0};
            beat_cnt_reg  <= '0;
            range_err_reg <= bad_mode;
          end
        end
        RUN: begin
          if ((beat_cnt_reg == total_reg) && !stage_valid_reg && (count_reg == '0)) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mem_rd_data_hold = hold;
  assign bus.out_data         = buf_reg[31:0];
  assign bus.out_valid        = out_valid_reg;
  assign done                 = done_reg;
  assign range_err            = range_err_reg;

endmodule

// File: tb/tb_compress_pack.sv
// Self-checking bench for compress_pack: random beats against a bit-queue reference of the packed stream.
module tb_compress_pack;
  logic       clk = 1'b0;
  logic       reset;
  logic       zeroize;
  logic       cmp_enable;
  logic [2:0] num_poly;
  logic [2:0] cmp_mode;
  logic       done;
  logic       range_err;

`ifdef ABR_CMP_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  compress_pack_if bus_if();

  compress_pack #(.BUF_W(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .zeroize    (zeroize),
    .cmp_enable (cmp_enable),
    .num_poly   (num_poly),
    .cmp_mode   (cmp_mode),
    .bus        (bus_if.slave),
    .done       (done),
    .range_err  (range_err)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [11:0] coef [0:1023];
  logic [31:0] exp_words [$];
  logic [31:0] got_words [$];
  bit          hold_seen;
  bit          timed_out;
  logic        done_after_start;
  int          beats_taken;

  function automatic int mode_to_d(input int mode);
    case (mode)
      0:       return 1;
      1:       return 4;
      2:       return 5;
      3:       return 10;
      4:       return 11;
      default: return 1;
    endcase
  endfunction

  task automatic fill_coef(input int nbeats, input int lo, input int hi);
    for (int i = 0; i < nbeats * 4; i++) coef[i] = 12'($urandom_range(hi, lo));
  endtask

  // Reference: compress every coefficient, push its bits into one LSB-first stream, cut into words
  task automatic build_expected(input int d, input int nbeats);
    bit          bits [$];
    int          y;
    logic [31:0] w;
    exp_words.delete();
    for (int b = 0; b < nbeats; b++) begin
      for (int l = 0; l < 4; l++) begin
        y = ((int'(coef[b*4+l]) << d) + 1664) / 3329;
        y = y % (1 << d);
        for (int k = 0; k < d; k++) bits.push_back(y[k]);
      end
    end
    while (bits.size() >= 32) begin
      for (int k = 0; k < 32; k++) w[k] = bits.pop_front();
      exp_words.push_back(w);
    end
  endtask

  function automatic logic [95:0] beat_data(input int b);
    logic [95:0] v;
    for (int l = 0; l < 4; l++) v[24*l +: 24] = {12'($urandom), coef[b*4+l]};
    return v;
  endfunction

  task automatic run_stream(input int mode, input int np, input int ready_pct,
                            input int stall0, input int extra, input bit poke);
    int total;
    int beat;
    int cyc;
    int extra_left;
    total = np * 64;
    beat = 0;
    cyc = 0;
    extra_left = extra;
    got_words.delete();
    hold_seen = 1'b0;
    timed_out = 1'b0;
    @(negedge clk);
    cmp_mode   = 3'(mode);
    num_poly   = 3'(np);
    cmp_enable = 1'b1;
    @(negedge clk);
    cmp_enable = 1'b0;
    done_after_start = done;
    forever begin
      if (beat < total) begin
        bus_if.mem_rd_data_valid = 1'b1;
        bus_if.mem_rd_data       = beat_data(beat);
      end else if (extra_left > 0) begin
        bus_if.mem_rd_data_valid = 1'b1;
        bus_if.mem_rd_data       = {$urandom, $urandom, $urandom};
        extra_left--;
      end else begin
        bus_if.mem_rd_data_valid = 1'b0;
      end
      bus_if.out_ready = (cyc < stall0) ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (poke && cyc == 7) begin
        cmp_enable = 1'b1;
        cmp_mode   = 3'd4;
        num_poly   = 3'd1;
      end else begin
        cmp_enable = 1'b0;
      end
      if (bus_if.mem_rd_data_hold) hold_seen = 1'b1;
      if (bus_if.mem_rd_data_valid && !bus_if.mem_rd_data_hold && beat < total) beat++;
      if (bus_if.out_valid && bus_if.out_ready) got_words.push_back(bus_if.out_data);
      @(negedge clk);
      cyc++;
      if (done && beat == total) break;
      if (cyc > 20000) begin
        timed_out = 1'b1;
        break;
      end
    end
    bus_if.mem_rd_data_valid = 1'b0;
    bus_if.out_ready         = 1'b0;
    cmp_enable               = 1'b0;
    beats_taken              = beat;
    $display("[TB] run mode=%0d np=%0d: %0d beats, %0d words, %0d cycles",
             mode, np, beat, got_words.size(), cyc);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    zeroize = 1'b0;
    cmp_enable = 1'b0;
    num_poly = 3'd1;
    cmp_mode = 3'd0;
    bus_if.mem_rd_data = '0;
    bus_if.mem_rd_data_valid = 1'b0;
    bus_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus_if.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid);
    end
    tests_run++;
    if (bus_if.out_data !== 32'h0) begin
      tests_failed++; $display("FAIL reset_out_data: got %h want 00000000", bus_if.out_data);
    end
    tests_run++;
    if (bus_if.mem_rd_data_hold !== 1'b0) begin
      tests_failed++; $display("FAIL reset_hold: got %b want 0", bus_if.mem_rd_data_hold);
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++; $display("FAIL reset_done: got %b want 1", done);
    end
    tests_run++;
    if (range_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_range_err: got %b want 0", range_err);
    end
  endtask

  task automatic test_const_stream(input string name, input int mode, input int x,
                                   input int nwords, input logic [31:0] word);
    fill_coef(64, x, x);
    run_stream(mode, 1, 70, 0, 0, 1'b0);
    tests_run++;
    if (timed_out || done_after_start !== 1'b0) begin
      tests_failed++; $display("FAIL %s_run: timeout=%0b done_after_start=%b want 0/0", name, timed_out, done_after_start);
    end
    tests_run++;
    if (got_words.size() != nwords) begin
      tests_failed++; $display("FAIL %s_count: got %0d words want %0d", name, got_words.size(), nwords);
    end
    for (int i = 0; i < got_words.size(); i++) begin
      tests_run++;
      if (got_words[i] !== word) begin
        tests_failed++; $display("FAIL %s_word%0d: got %h want %h", name, i, got_words[i], word);
      end
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++; $display("FAIL %s_done: got %b want 1", name, done);
    end
  endtask

  task automatic test_random_modes();
    int np;
    int n;
    for (int mode = 0; mode < 5; mode++) begin
      np = $urandom_range(4, 1);
      fill_coef(np * 64, 0, 3328);
      build_expected(mode_to_d(mode), np * 64);
      run_stream(mode, np, 60, 0, 3, mode == 2);
      tests_run++;
      if (timed_out || got_words.size() != exp_words.size()) begin
        tests_failed++;
        $display("FAIL random_m%0d_count: got %0d words (timeout=%0b) want %0d", mode, got_words.size(), timed_out, exp_words.size());
      end
      n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
      for (int i = 0; i < n; i++) begin
        tests_run++;
        if (got_words[i] !== exp_words[i]) begin
          tests_failed++; $display("FAIL random_m%0d_word%0d: got %h want %h", mode, i, got_words[i], exp_words[i]);
        end
      end
      tests_run++;
      if (beats_taken != np * 64 || range_err !== 1'b0) begin
        tests_failed++; $display("FAIL random_m%0d_end: beats %0d range_err %b want %0d 0", mode, beats_taken, range_err, np * 64);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    fill_coef(256, 0, 3328);
    build_expected(11, 256);
    run_stream(4, 4, 100, 20, 0, 1'b0);
    tests_run++;
    if (hold_seen !== 1'b1) begin
      tests_failed++; $display("FAIL backpressure_hold: got %b want 1", hold_seen);
    end
    tests_run++;
    if (timed_out || got_words.size() != 352) begin
      tests_failed++; $display("FAIL backpressure_count: got %0d words (timeout=%0b) want 352", got_words.size(), timed_out);
    end
    n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (got_words[i] !== exp_words[i]) begin
        tests_failed++; $display("FAIL backpressure_word%0d: got %h want %h", i, got_words[i], exp_words[i]);
      end
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++; $display("FAIL backpressure_done: got %b want 1", done);
    end
  endtask

  task automatic test_zeroize();
    int  beat = 0;
    int  cyc = 0;
    bit  late_valid = 1'b0;
    fill_coef(64, 0, 3328);
    @(negedge clk);
    cmp_mode = 3'd3;
    num_poly = 3'd1;
    cmp_enable = 1'b1;
    @(negedge clk);
    cmp_enable = 1'b0;
    bus_if.out_ready = 1'b1;
    while (beat < 10 && cyc < 500) begin
      bus_if.mem_rd_data_valid = 1'b1;
      bus_if.mem_rd_data = beat_data(beat);
      if (!bus_if.mem_rd_data_hold) beat++;
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (beat != 10) begin
      tests_failed++; $display("FAIL zeroize_reach_beat10: got %0d beats want 10", beat);
    end
    zeroize = 1'b1;
    bus_if.mem_rd_data_valid = 1'b0;
    @(negedge clk);
    zeroize = 1'b0;
    tests_run++;
    if (bus_if.out_valid !== 1'b0 || done !== 1'b1) begin
      tests_failed++; $display("FAIL zeroize_next: out_valid %b done %b want 0 1", bus_if.out_valid, done);
    end
    repeat (10) begin
      @(negedge clk);
      if (bus_if.out_valid !== 1'b0) late_valid = 1'b1;
    end
    tests_run++;
    if (late_valid || bus_if.mem_rd_data_hold !== 1'b0) begin
      tests_failed++; $display("FAIL zeroize_quiet: late_valid %b hold %b want 0 0", late_valid, bus_if.mem_rd_data_hold);
    end
    bus_if.out_ready = 1'b0;
    $display("[TB] zeroize after %0d beats", beat);
  endtask

  task automatic test_bad_mode();
    int n;
    fill_coef(64, 0, 3328);
    build_expected(1, 64);
    run_stream(6, 1, 80, 0, 0, 1'b0);
    tests_run++;
    if (range_err !== 1'b1) begin
      tests_failed++; $display("FAIL bad_mode_range_err: got %b want 1", range_err);
    end
    tests_run++;
    if (timed_out || got_words.size() != exp_words.size()) begin
      tests_failed++; $display("FAIL bad_mode_count: got %0d words want %0d", got_words.size(), exp_words.size());
    end
    n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (got_words[i] !== exp_words[i]) begin
        tests_failed++; $display("FAIL bad_mode_word%0d: got %h want %h", i, got_words[i], exp_words[i]);
      end
    end
    fill_coef(64, 0, 3328);
    run_stream(1, 1, 80, 0, 0, 1'b0);
    tests_run++;
    if (range_err !== 1'b0) begin
      tests_failed++; $display("FAIL bad_mode_clear: got %b want 0", range_err);
    end
  endtask

  task automatic test_range_check();
    int n;
    fill_coef(64, 0, 4095);
    coef[13] = 12'd3329;
    build_expected(5, 64);
    run_stream(2, 1, 80, 0, 0, 1'b0);
    tests_run++;
    if (timed_out || got_words.size() != exp_words.size()) begin
      tests_failed++; $display("FAIL range_count: got %0d words want %0d", got_words.size(), exp_words.size());
    end
    n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (got_words[i] !== exp_words[i]) begin
        tests_failed++; $display("FAIL range_word%0d: got %h want %h", i, got_words[i], exp_words[i]);
      end
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (range_err !== RANGE_EN) begin
      tests_failed++; $display("FAIL range_sticky: got %b want %b", range_err, RANGE_EN);
    end
    fill_coef(64, 0, 3328);
    run_stream(0, 1, 80, 0, 0, 1'b0);
    tests_run++;
    if (range_err !== 1'b0) begin
      tests_failed++; $display("FAIL range_clear_on_start: got %b want 0", range_err);
    end
  endtask

  initial begin
    test_reset();
    test_const_stream("d1_ones", 0, 1665, 8, 32'hFFFFFFFF);
    test_const_stream("d1_zero", 0, 832, 8, 32'h00000000);
    test_const_stream("d4_wrap", 1, 3328, 32, 32'h00000000);
    test_random_modes();
    test_backpressure();
    test_zeroize();
    test_bad_mode();
    test_range_check();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
